// File: rtl/kval_sweep_sequencer.sv
// Linear sweep sequencer for the 40-bit synthesizer tuning word kval.
// Define KVAL_SWEEP_BIDIR_EN for a continuous triangle sweep instead of a single pass.
module kval_sweep_sequencer #(
    parameter int KW     = 40,
    parameter int DW     = 24,
    parameter int SETTLE = 48
) (
    input  logic          CLK67MHZ,
    input  logic          resetPort,
    input  logic          start,
    input  logic          abort,
    input  logic [KW-1:0] start_k,
    input  logic [KW-1:0] stop_k,
    input  logic [KW-1:0] step_k,
    input  logic [DW-1:0] dwell,
    output logic [KW-1:0] kval,
    output logic          busy,
    output logic          step_strobe,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] kval_q, kval_d;
    logic [KW-1:0] hi_q, hi_d;
    logic [KW-1:0] step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [KW:0]   up_sum;
    logic [KW-1:0] up_next;
`ifdef KVAL_SWEEP_BIDIR_EN
    logic [KW-1:0] lo_q, lo_d;
    logic          dir_q, dir_d;
    logic [KW:0]   dn_diff;
    logic [KW-1:0] dn_next;
`endif

    // Sum kept one bit wider so a carry out clamps to the stop word instead of wrapping
    assign up_sum  = {1'b0, kval_q} + {1'b0, step_q};
    assign up_next = (up_sum[KW] || (up_sum[KW-1:0] >= hi_q)) ? hi_q : up_sum[KW-1:0];
`ifdef KVAL_SWEEP_BIDIR_EN
    assign dn_diff = {1'b0, kval_q} - {1'b0, step_q};
    assign dn_next = (dn_diff[KW] || (dn_diff[KW-1:0] <= lo_q)) ? lo_q : dn_diff[KW-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kval_d   = kval_q;
        hi_d     = hi_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
`ifdef KVAL_SWEEP_BIDIR_EN
        lo_d     = lo_q;
        dir_d    = dir_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((step_k == '0) || (start_k > stop_k)) begin
                        err_d = 1'b1;
                    end else begin
                        hi_d     = stop_k;
                        step_d   = step_k;
                        dwell_d  = (dwell == '0) ? DW'(1) : dwell;
                        kval_d   = start_k;
                        strobe_d = 1'b1;
                        err_d    = 1'b0;
                        cnt_d    = '0;
                        state_d  = S_SETTLE;
`ifdef KVAL_SWEEP_BIDIR_EN
                        lo_d     = start_k;
                        dir_d    = 1'b1;
`endif
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == DW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DWELL;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_DWELL: begin
                if (cnt_q == dwell_q - DW'(1)) begin
                    cnt_d = '0;
`ifdef KVAL_SWEEP_BIDIR_EN
                    state_d  = S_SETTLE;
                    strobe_d = 1'b1;
                    if (dir_q) begin
                        if (kval_q == hi_q) begin
                            dir_d  = 1'b0;
                            kval_d = dn_next;
                        end else begin
                            kval_d = up_next;
                        end
                    end else begin
                        if (kval_q == lo_q) begin
                            dir_d  = 1'b1;
                            kval_d = up_next;
                        end else begin
                            kval_d = dn_next;
                        end
                    end
`else
                    if (kval_q == hi_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        kval_d   = up_next;
                        strobe_d = 1'b1;
                        state_d  = S_SETTLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides any step or completion decided above
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            kval_d   = kval_q;
            strobe_d = 1'b0;
            done_d   = 1'b0;
            cnt_d    = '0;
        end
        busy_d = (state_d == S_SETTLE) || (state_d == S_DWELL);
    end

    always_ff @(posedge CLK67MHZ or posedge resetPort) begin
        if (resetPort) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kval_q   <= '0;
            hi_q     <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef KVAL_SWEEP_BIDIR_EN
            lo_q     <= '0;
            dir_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kval_q   <= kval_d;
            hi_q     <= hi_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
`ifdef KVAL_SWEEP_BIDIR_EN
            lo_q     <= lo_d;
            dir_q    <= dir_d;
`endif
        end
    end

    assign kval        = kval_q;
    assign busy        = busy_q;
    assign step_strobe = strobe_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_kval_sweep_sequencer.sv
// Scoreboard bench for kval_sweep_sequencer; KVAL_SWEEP_BIDIR_EN selects the triangle-sweep scenario.
module tb_kval_sweep_sequencer;

    localparam int KW = 40;
    localparam int DW = 24;

    logic          CLK67MHZ = 1'b0;
    logic          resetPort = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KW-1:0] start_k = '0;
    logic [KW-1:0] stop_k = '0;
    logic [KW-1:0] step_k = '0;
    logic [DW-1:0] dwell = '0;
    logic [KW-1:0] kval;
    logic          busy;
    logic          step_strobe;
    logic          done;
    logic          err;

    kval_sweep_sequencer dut (
        .CLK67MHZ   (CLK67MHZ),
        .resetPort  (resetPort),
        .start      (start),
        .abort      (abort),
        .start_k    (start_k),
        .stop_k     (stop_k),
        .step_k     (step_k),
        .dwell      (dwell),
        .kval       (kval),
        .busy       (busy),
        .step_strobe(step_strobe),
        .done       (done),
        .err        (err)
    );

    always #5 CLK67MHZ = ~CLK67MHZ;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;

    always @(posedge CLK67MHZ) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [KW-1:0] k;
        int unsigned at;
    } ev_t;

    ev_t sbq[$];

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic ev(input bit d, input logic [KW-1:0] k, input int unsigned off);
        ev_t e;
        e.is_done = d;
        e.k       = k;
        e.at      = t0 + off;
        sbq.push_back(e);
    endtask

    task automatic go(input logic [KW-1:0] s, input logic [KW-1:0] e,
                      input logic [KW-1:0] st, input logic [DW-1:0] d);
        start_k = s;
        stop_k  = e;
        step_k  = st;
        dwell   = d;
        start   = 1'b1;
        @(negedge CLK67MHZ);
        start   = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < maxc) begin
            @(negedge CLK67MHZ);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s pending events %0d want 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    always @(negedge CLK67MHZ) begin : monitor
        ev_t e;
        if (!resetPort && (step_strobe || done)) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event strobe=%0b done=%0b kval=%0h cyc=%0d",
                         step_strobe, done, kval, cyc);
            end else begin
                e = sbq.pop_front();
                if ((e.is_done != done) || (step_strobe == done) ||
                    (!e.is_done && (kval !== e.k)) || (cyc != e.at) ||
                    (busy != !e.is_done)) begin
                    errors++;
                    $display("FAIL event got strobe=%0b done=%0b kval=%0h busy=%0b cyc=%0d want done=%0b kval=%0h cyc=%0d",
                             step_strobe, done, kval, busy, cyc, e.is_done, e.k, e.at);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK67MHZ);
        resetPort = 1'b0;
        @(negedge CLK67MHZ);
        chk("rst_kval", kval, 40'd0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_strobe", step_strobe, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_err", err, 1'b0);

`ifdef KVAL_SWEEP_BIDIR_EN
        t0 = cyc + 1;
        ev(1'b0, 40'd100, 0);
        ev(1'b0, 40'd110, 50);
        ev(1'b0, 40'd120, 100);
        ev(1'b0, 40'd110, 150);
        ev(1'b0, 40'd100, 200);
        ev(1'b0, 40'd110, 250);
        go(40'd100, 40'd120, 40'd10, 24'd2);
        chkb("bidir_busy", busy, 1'b1);
        repeat (260) @(negedge CLK67MHZ);
        abort = 1'b1;
        @(negedge CLK67MHZ);
        abort = 1'b0;
        chkb("bidir_abort_busy", busy, 1'b0);
        chk("bidir_abort_kval", kval, 40'd110);
        chkb("bidir_done", done, 1'b0);
        repeat (150) @(negedge CLK67MHZ);
        drain("bidir", 1);
`else
        // basic sweep, hold 48+5
        t0 = cyc + 1;
        ev(1'b0, 40'd100, 0);
        ev(1'b0, 40'd110, 53);
        ev(1'b0, 40'd120, 106);
        ev(1'b0, 40'd130, 159);
        ev(1'b1, 40'd0, 212);
        go(40'd100, 40'd130, 40'd10, 24'd5);
        chkb("basic_busy", busy, 1'b1);
        chk("basic_first", kval, 40'd100);
        drain("basic", 300);
        repeat (2) @(negedge CLK67MHZ);
        chk("basic_final", kval, 40'd130);
        chkb("basic_idle", busy, 1'b0);

        // clamp at stop, dwell 0 acts as 1 -> hold 49
        t0 = cyc + 1;
        ev(1'b0, 40'd0, 0);
        ev(1'b0, 40'd10, 49);
        ev(1'b0, 40'd20, 98);
        ev(1'b0, 40'd25, 147);
        ev(1'b1, 40'd0, 196);
        go(40'd0, 40'd25, 40'd10, 24'd0);
        drain("clamp", 300);
        repeat (2) @(negedge CLK67MHZ);

        // top of range, no wrap, hold 50
        t0 = cyc + 1;
        ev(1'b0, 40'hFF_FFFF_FFFB, 0);
        ev(1'b0, 40'hFF_FFFF_FFFF, 50);
        ev(1'b1, 40'd0, 100);
        go(40'hFF_FFFF_FFFB, 40'hFF_FFFF_FFFF, 40'd8, 24'd2);
        drain("nowrap", 200);
        repeat (2) @(negedge CLK67MHZ);
        chk("nowrap_final", kval, 40'hFF_FFFF_FFFF);

        // zero step
        go(40'd3, 40'd9, 40'd0, 24'd1);
        chkb("step0_err", err, 1'b1);
        chkb("step0_busy", busy, 1'b0);
        chk("step0_kval", kval, 40'hFF_FFFF_FFFF);
        repeat (2) @(negedge CLK67MHZ);

        // single point clears err
        t0 = cyc + 1;
        ev(1'b0, 40'd7, 0);
        ev(1'b1, 40'd0, 49);
        go(40'd7, 40'd7, 40'd5, 24'd1);
        chkb("single_err", err, 1'b0);
        drain("single", 100);
        repeat (2) @(negedge CLK67MHZ);

        // start above stop
        go(40'd50, 40'd40, 40'd1, 24'd1);
        chkb("order_err", err, 1'b1);
        chk("order_kval", kval, 40'd7);
        repeat (2) @(negedge CLK67MHZ);

        // abort in dwell of 110, hold 68
        t0 = cyc + 1;
        ev(1'b0, 40'd100, 0);
        ev(1'b0, 40'd110, 68);
        go(40'd100, 40'd130, 40'd10, 24'd20);
        chkb("abort_err_clr", err, 1'b0);
        repeat (120) @(negedge CLK67MHZ);
        abort = 1'b1;
        @(negedge CLK67MHZ);
        abort = 1'b0;
        chkb("abort_busy", busy, 1'b0);
        chk("abort_kval", kval, 40'd110);
        repeat (150) @(negedge CLK67MHZ);
        drain("abort", 1);
        chk("abort_hold", kval, 40'd110);

        // async reset while settling
        t0 = cyc + 1;
        ev(1'b0, 40'd100, 0);
        go(40'd100, 40'd130, 40'd10, 24'd5);
        repeat (10) @(negedge CLK67MHZ);
        @(posedge CLK67MHZ);
        #2 resetPort = 1'b1;
        #1;
        chk("mrst_kval", kval, 40'd0);
        chkb("mrst_busy", busy, 1'b0);
        chkb("mrst_strobe", step_strobe, 1'b0);
        chkb("mrst_done", done, 1'b0);
        chkb("mrst_err", err, 1'b0);
        @(negedge CLK67MHZ);
        resetPort = 1'b0;
        drain("mrst", 1);
        @(negedge CLK67MHZ);

        t0 = cyc + 1;
        ev(1'b0, 40'd0, 0);
        ev(1'b0, 40'd10, 49);
        ev(1'b0, 40'd20, 98);
        ev(1'b0, 40'd25, 147);
        ev(1'b1, 40'd0, 196);
        go(40'd0, 40'd25, 40'd10, 24'd0);
        drain("post_rst", 300);
        repeat (2) @(negedge CLK67MHZ);
        chk("post_rst_final", kval, 40'd25);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
